// File: rtl/branch_ctrl.sv
// Program sequencer / branch control for the fetch unit: IDLE/RUN/DONE handshake,
// 16-entry target LUT, jump/branch decode. BRANCH_CTRL_CYCLE_CNT_EN builds the cycle counter.
module branch_ctrl #(
  parameter int LUT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic [8:0]       Instr,
  input  logic             LutWe,
  input  logic [3:0]       LutAddr,
  input  logic [9:0]       LutData,
  output logic             Start,
  output logic             Jump,
  output logic             BOE,
  output logic [9:0]       Target,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] OP_JMP  = 4'b1110;
  localparam logic [3:0] OP_BOE  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t     state, state_nxt;
  logic [9:0] lut [LUT_DEPTH];
  logic [3:0] opcode;
  logic       unused_bits;

  assign opcode      = Instr[8:5];
  assign unused_bits = Instr[4];

  always_ff @(posedge clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Start     = 1'b1;
    Done      = 1'b0;
    Jump      = 1'b0;
    BOE       = 1'b0;
    Target    = '0;
    case (state)
      IDLE: if (Go) state_nxt = RUN;
      RUN: begin
        Start = 1'b0;
        case (opcode)
          OP_JMP: begin
            Jump   = 1'b1;
            Target = lut[Instr[3:0]];
          end
          OP_BOE: begin
            BOE    = 1'b1;
            Target = lut[Instr[3:0]];
          end
          OP_HALT: state_nxt = DONE;
          default: ;
        endcase
      end
      DONE: begin
        Done = 1'b1;
        if (!Go) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // LUT is frozen while a program runs; reads see the pre-edge value
  always_ff @(posedge clock) begin
    if (Reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else if (LutWe && state != RUN) begin
      lut[LutAddr] <= LutData;
    end
  end

`ifdef BRANCH_CTRL_CYCLE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [CNT_W-1:0] cnt;

  // Saturating count of RUN cycles, restarted on IDLE->RUN
  always_ff @(posedge clock) begin
    if (Reset)                      cnt <= '0;
    else if (state == IDLE && Go)   cnt <= '0;
    else if (state == RUN && ~&cnt) cnt <= cnt + CNT_ONE;
  end

  assign CycleCount = cnt;
`else
  assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed steps from the test plan, then random cycles,
// compared against a behavioural phase/LUT/counter model. Second instance uses CNT_W=4.
module tb_branch_ctrl;

  logic        clock = 1'b0;
  logic        Reset, Go, LutWe;
  logic [8:0]  Instr;
  logic [3:0]  LutAddr;
  logic [9:0]  LutData;
  logic        Start, Jump, BOE, Done;
  logic [9:0]  Target;
  logic [15:0] CycleCount;
  logic        s4_start, s4_jump, s4_boe, s4_done;
  logic [9:0]  s4_target;
  logic [3:0]  s4_count;

  int checks   = 0;
  int failures = 0;

  // model
  localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;
  int          phase;
  int unsigned runs;
  logic [9:0]  lut_m [16];

  always #5 clock = ~clock;

  branch_ctrl #(.LUT_DEPTH(16), .CNT_W(16)) dut (
    .clock(clock), .Reset(Reset), .Go(Go), .Instr(Instr), .LutWe(LutWe),
    .LutAddr(LutAddr), .LutData(LutData), .Start(Start), .Jump(Jump), .BOE(BOE),
    .Target(Target), .Done(Done), .CycleCount(CycleCount));

  branch_ctrl #(.LUT_DEPTH(16), .CNT_W(4)) dut4 (
    .clock(clock), .Reset(Reset), .Go(Go), .Instr(Instr), .LutWe(LutWe),
    .LutAddr(LutAddr), .LutData(LutData), .Start(s4_start), .Jump(s4_jump), .BOE(s4_boe),
    .Target(s4_target), .Done(s4_done), .CycleCount(s4_count));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_count(input int unsigned mx);
`ifdef BRANCH_CTRL_CYCLE_CNT_EN
    return 16'((runs > mx) ? mx : runs);
`else
    return 16'(mx & 0);
`endif
  endfunction

  // one clock: drive after negedge, check settled outputs, then advance the model at posedge
  task automatic cyc(input logic rst, input logic go, input logic we, input logic [3:0] a,
                     input logic [9:0] d, input logic [8:0] ins, input string tag);
    logic [3:0] op;
    logic       ej, eb;
    logic [9:0] et;
    @(negedge clock);
    Reset = rst; Go = go; LutWe = we; LutAddr = a; LutData = d; Instr = ins;
    #1;
    op = ins[8:5];
    ej = (phase == P_RUN) && op == 4'hE;
    eb = (phase == P_RUN) && op == 4'hD;
    et = (ej || eb) ? lut_m[ins[3:0]] : 10'd0;
    chk({tag, ".start"},  16'(Start),  16'(phase != P_RUN));
    chk({tag, ".done"},   16'(Done),   16'(phase == P_DONE));
    chk({tag, ".jump"},   16'(Jump),   16'(ej));
    chk({tag, ".boe"},    16'(BOE),    16'(eb));
    chk({tag, ".target"}, 16'(Target), 16'(et));
    chk({tag, ".count"},  CycleCount,  exp_count(32'hFFFF));
    chk({tag, ".start4"}, 16'(s4_start), 16'(phase != P_RUN));
    chk({tag, ".target4"}, 16'(s4_target), 16'(et));
    chk({tag, ".count4"}, 16'(s4_count), exp_count(15));
    @(posedge clock);
    if (rst) begin
      phase = P_IDLE; runs = 0;
      foreach (lut_m[i]) lut_m[i] = '0;
    end else begin
      if (phase != P_RUN && we) lut_m[a] = d;
      case (phase)
        P_IDLE: if (go) begin phase = P_RUN; runs = 0; end
        P_RUN: begin
          if (runs < 100000) runs++;
          if (op == 4'hF) phase = P_DONE;
        end
        default: if (!go) phase = P_IDLE;
      endcase
    end
  endtask

  function automatic logic [8:0] plain_instr();
    logic [8:0] r;
    r = 9'($urandom);
    r[8:5] = 4'($urandom_range(0, 12));
    return r;
  endfunction

  initial begin
    Reset = 1'b1; Go = 1'b0; LutWe = 1'b0; LutAddr = '0; LutData = '0; Instr = '0;
    phase = P_IDLE; runs = 0;
    foreach (lut_m[i]) lut_m[i] = 10'h155;  // model unknown until reset edge

    // reset / idle
    cyc(1, 0, 0, 0, 0, 0, "rst0");
    cyc(1, 0, 0, 0, 0, 0, "rst1");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, plain_instr(), "idle");
    cyc(0, 0, 0, 0, 0, 9'b1110_0_0011, "idle_jmp_masked");

    // LUT write and jump; write during RUN is ignored
    cyc(0, 0, 1, 4'd3, 10'h120, 0, "lutwr3");
    cyc(0, 1, 0, 0, 0, 0, "go_pulse");
    cyc(0, 0, 1, 4'd3, 10'h055, 9'b1110_0_0011, "jmp3");
    cyc(0, 0, 0, 0, 0, 9'b1110_0_0011, "jmp3_again");
    cyc(0, 0, 0, 0, 0, 9'b1111_0_0000, "halt1");
    cyc(0, 0, 1, 4'd5, 10'h3FE, 0, "done_lutwr5");
    cyc(0, 0, 0, 0, 0, 0, "idle2");

    // branch offset, then same-entry read-during-write in IDLE
    cyc(0, 1, 1, 4'd5, 10'h3FE, 0, "go2");
    cyc(0, 0, 0, 0, 0, 9'b1101_0_0101, "boe5");
    cyc(0, 0, 0, 0, 0, 9'b1110_1_0011, "jmp3_held");
    cyc(0, 0, 0, 0, 0, 9'b1111_1_1111, "halt2");
    cyc(0, 0, 0, 0, 0, 0, "idle3");
    cyc(0, 0, 1, 4'd5, 10'h001, 0, "rdw_wr");
    cyc(0, 1, 0, 0, 0, 0, "go3");
    cyc(0, 0, 0, 0, 0, 9'b1101_0_0101, "rdw_new");
    cyc(0, 0, 0, 0, 0, 9'b1111_0_0000, "halt3");

    // halt handshake with Go held high
    cyc(0, 1, 0, 0, 0, 0, "done_go_hi");
    cyc(0, 0, 0, 0, 0, 0, "to_idle");
    cyc(0, 1, 0, 0, 0, 0, "go4");
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, plain_instr(), "plain");
    cyc(0, 1, 0, 0, 0, 9'b1111_0_0000, "halt4");
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 9'b1110_0_0011, "done_hold");
    cyc(0, 0, 0, 0, 0, 0, "done_release");
    cyc(0, 0, 0, 0, 0, 0, "idle4");

    // reset in third RUN cycle clears LUT and count
    cyc(0, 1, 0, 0, 0, 0, "go5");
    cyc(0, 0, 0, 0, 0, plain_instr(), "run5a");
    cyc(0, 0, 0, 0, 0, plain_instr(), "run5b");
    cyc(1, 1, 1, 4'd2, 10'h3AA, 9'b1110_0_0011, "rst_mid");
    cyc(0, 0, 0, 0, 0, 0, "after_rst");
    cyc(0, 1, 0, 0, 0, 0, "go6");
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 0, {5'b1110_0, 4'(i)}, "lut_zero");
    cyc(0, 0, 0, 0, 0, 9'b1111_0_0000, "halt6");
    cyc(0, 0, 0, 0, 0, 0, "idle6");

    // saturation: 20 RUN cycles without HALT
    cyc(0, 1, 0, 0, 0, 0, "go7");
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, plain_instr(), "sat");
    cyc(0, 0, 0, 0, 0, 9'b1111_0_0000, "halt7");
    cyc(0, 0, 0, 0, 0, 0, "idle7");

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [8:0] ins;
      ins = 9'($urandom);
      if ($urandom_range(0, 7) == 0) ins[8:5] = 4'hF;
      else if (ins[8:5] == 4'hF) ins[8:5] = 4'($urandom_range(0, 1) ? 4'hE : 4'hD);
      cyc(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)), 4'($urandom), 10'($urandom), ins, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
